// File: rtl/round_timer_ctrl.sv
// -----------------------------------------------------------------------------
// round_timer_ctrl
//   Sequences a whack-a-mole game of N rounds against an interval timer/display
//   block. For each round it holds the timer in reset for one cycle (ARM). It
//   then lets the timer run until the player hits or the timer times out (RUN).
//   Next it holds the timer in reset for an inter-round pause (GAP). After the
//   last round it emits a single all_done pulse (DONE) and returns to IDLE.
//
// Ports
//   clk           master clock, all state on the rising edge
//   rst           asynchronous, active-high reset
//   start         1-cycle game request, honoured in IDLE only
//   abort         level; cancels a running game, back to IDLE next cycle
//   cfg_interval  seconds per round, latched on an accepted start
//   cfg_dir       timer direction (1 = up), latched on an accepted start
//   num_rounds    rounds per game, latched on an accepted start
//   hit           player hit pulse, honoured in RUN only
//   timeout       terminal-count pulse from the timer, honoured in RUN only
//   interval      interval to the timer (constant for the whole game)
//   dir           direction to the timer (constant for the whole game)
//   timer_rst_n   timer reset, low holds/restarts the timer; high only in RUN
//   busy          high while a game is in ARM/RUN/GAP
//   round_idx     current round, 0-based; held after the game ends
//   hits          hits this game (saturating); held after the game ends
//   round_done    1-cycle pulse when a round ends
//   round_hit     qualifies round_done: 1 = hit, 0 = timeout
//   all_done      1-cycle pulse when a game completes
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module round_timer_ctrl #(
   parameter int ROUNDS_W   = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [2:0]          cfg_interval,
   input  logic                cfg_dir,
   input  logic [ROUNDS_W-1:0] num_rounds,
   input  logic                hit,
   input  logic                timeout,
   output logic [2:0]          interval,
   output logic                dir,
   output logic                timer_rst_n,
   output logic                busy,
   output logic [ROUNDS_W-1:0] round_idx,
   output logic [ROUNDS_W-1:0] hits,
   output logic                round_done,
   output logic                round_hit,
   output logic                all_done
);

   // A pause of zero cycles would merge GAP into ARM, so it is widened to one.
   localparam int GAP_EFF   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
   localparam int GAP_CNT_W = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_EFF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_GAP,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [2:0]            interval_q, interval_d;
   logic                  dir_q, dir_d;
   logic [ROUNDS_W-1:0]   num_rounds_q, num_rounds_d;
   logic [ROUNDS_W-1:0]   round_idx_q, round_idx_d;
   logic [ROUNDS_W-1:0]   hits_q, hits_d;
   logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic                  timer_rst_n_q, timer_rst_n_d;
   logic                  busy_q, busy_d;
   logic                  round_done_q, round_done_d;
   logic                  round_hit_q, round_hit_d;
   logic                  all_done_q, all_done_d;

   logic                  last_round;
   logic [ROUNDS_W-1:0]   hits_inc;

   assign last_round = (round_idx_q == num_rounds_q - ROUNDS_W'(1));
   assign hits_inc   = (hits_q == '1) ? hits_q : hits_q + ROUNDS_W'(1);

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      interval_d   = interval_q;
      dir_d        = dir_q;
      num_rounds_d = num_rounds_q;
      round_idx_d  = round_idx_q;
      hits_d       = hits_q;
      gap_cnt_d    = gap_cnt_q;
      round_done_d = 1'b0;
      round_hit_d  = 1'b0;
      all_done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_rounds != '0) begin
                  interval_d   = cfg_interval;
                  dir_d        = cfg_dir;
                  num_rounds_d = num_rounds;
                  round_idx_d  = '0;
                  hits_d       = '0;
                  state_d      = S_ARM;
               end else begin
                  // Empty game: report completion without ever leaving IDLE.
                  all_done_d = 1'b1;
               end
            end
         end

         S_ARM: state_d = S_RUN;

         S_RUN: begin
            // Hit is checked first so a coincident timeout is not a second event.
            if (hit) begin
               hits_d       = hits_inc;
               round_done_d = 1'b1;
               round_hit_d  = 1'b1;
               gap_cnt_d    = GAP_LOAD;
               state_d      = S_GAP;
            end else if (timeout) begin
               round_done_d = 1'b1;
               gap_cnt_d    = GAP_LOAD;
               state_d      = S_GAP;
            end
         end

         S_GAP: begin
            if (gap_cnt_q == '0) begin
               if (last_round) begin
                  all_done_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  round_idx_d = round_idx_q + ROUNDS_W'(1);
                  state_d     = S_ARM;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the state logic decided, including a hit or
      // timeout in the same cycle: no pulses, no hit counted.
      if (abort && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         hits_d       = hits_q;
         round_idx_d  = round_idx_q;
         round_done_d = 1'b0;
         round_hit_d  = 1'b0;
         all_done_d   = 1'b0;
      end

      // Registered outputs are decoded from the next state so they line up
      // with the state they describe.
      timer_rst_n_d = (state_d == S_RUN);
      busy_d        = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_GAP);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         interval_q    <= 3'd0;
         dir_q         <= 1'b1;
         num_rounds_q  <= '0;
         round_idx_q   <= '0;
         hits_q        <= '0;
         gap_cnt_q     <= '0;
         timer_rst_n_q <= 1'b0;
         busy_q        <= 1'b0;
         round_done_q  <= 1'b0;
         round_hit_q   <= 1'b0;
         all_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         interval_q    <= interval_d;
         dir_q         <= dir_d;
         num_rounds_q  <= num_rounds_d;
         round_idx_q   <= round_idx_d;
         hits_q        <= hits_d;
         gap_cnt_q     <= gap_cnt_d;
         timer_rst_n_q <= timer_rst_n_d;
         busy_q        <= busy_d;
         round_done_q  <= round_done_d;
         round_hit_q   <= round_hit_d;
         all_done_q    <= all_done_d;
      end
   end

   assign interval    = interval_q;
   assign dir         = dir_q;
   assign timer_rst_n = timer_rst_n_q;
   assign busy        = busy_q;
   assign round_idx   = round_idx_q;
   assign hits        = hits_q;
   assign round_done  = round_done_q;
   assign round_hit   = round_hit_q;
   assign all_done    = all_done_q;

endmodule
